// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and datapath mux/ALU select values.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK,
    S_LUI, S_AUIPC, S_TRAP
  } mc_state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // R-type has no immediate; it falls through to the I format harmlessly.
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:            return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_maindec_if.sv
// Control bundle between the main decoder (master) and the datapath (slave).
interface multicycle_maindec_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [1:0] ALUOp;
  logic       Illegal;

  modport master (
    input  op, funct3, Zero, MemReady,
    output MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp, Illegal
  );

  modport slave (
    output op, funct3, Zero, MemReady,
    input  MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp, Illegal
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory access completion: either the MemReady handshake or a fixed count
// of wait cycles, restarting from zero on every new access.
module mem_wait_timer #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LATENCY   = 0,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic done
);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  logic [CNT_W-1:0] wait_cnt;

  assign done = active & ((MEM_HANDSHAKE != 0) ? mem_ready : (wait_cnt == LAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wait_cnt <= '0;
    else if (!active || done) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end
endmodule

// File: rtl/multicycle_maindec.sv
// Main control FSM of the multicycle RV32I core: one state per instruction
// phase, Moore outputs plus done-qualified fetch enables and branch PCWrite.
module multicycle_maindec
  import riscv_mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LATENCY   = 0,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_maindec_if.master bus
);
  mc_state_t  state, state_n;
  logic       mem_req, mem_write, done;
  logic       ir_write, pc_update, branch, reg_write, adr_src;
  logic [1:0] src_a, src_b, res_src, alu_op;
  logic       taken, illegal_q;
  logic       unused_f3;

  mem_wait_timer #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE),
    .MEM_LATENCY  (MEM_LATENCY),
    .CNT_W        (CNT_W)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .active   (bus.MemReq),
    .mem_ready(bus.MemReady),
    .done     (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     illegal_q <= 1'b0;
    else if (state == S_DECODE && state_n == S_TRAP) illegal_q <= 1'b1;
  end

  assign taken     = bus.funct3[0] ? ~bus.Zero : bus.Zero;
  assign unused_f3 = ^bus.funct3[2:1];

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    src_a     = SRCA_PC;
    src_b     = SRCB_RD2;
    res_src   = RES_ALUOUT;
    alu_op    = ALUOP_ADD;
    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RES_ALURESULT;
        if (done) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_n   = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut = OldPC + imm is the branch/jal target for later states
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXECR;
          OP_I:         state_n = S_EXECI;
          OP_BRANCH:    state_n = S_BRANCH;
          OP_JAL:       state_n = S_JAL;
          OP_JALR:      state_n = S_JALR;
          OP_LUI:       state_n = S_LUI;
          OP_AUIPC:     state_n = S_AUIPC;
          default:      state_n = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        state_n = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (done) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        res_src   = RES_DATA;
        reg_write = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (done) state_n = S_FETCH;
      end
      S_EXECR: begin
        src_a   = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_n   = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        state_n = S_FETCH;
      end
      S_JAL: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
        state_n   = S_ALUWB;
      end
      S_JALR: begin
        // target goes straight from ALUResult; link is computed next cycle
        src_a     = SRCA_RD1;
        src_b     = SRCB_IMM;
        res_src   = RES_ALURESULT;
        pc_update = 1'b1;
        state_n   = S_JALRLINK;
      end
      S_JALRLINK: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_FOUR;
        state_n = S_ALUWB;
      end
      S_LUI: begin
        src_a   = SRCA_ZERO;
        src_b   = SRCB_IMM;
        state_n = S_ALUWB;
      end
      S_AUIPC: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        state_n = S_ALUWB;
      end
      S_TRAP: state_n = S_TRAP;
    endcase
  end

  // memory strobes must drop the instant reset rises, not at the next edge
  assign bus.MemReq    = mem_req & ~reset;
  assign bus.MemWrite  = mem_write & ~reset;
  assign bus.AdrSrc    = adr_src;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_update | (branch & taken);
  assign bus.RegWrite  = reg_write;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ResultSrc = res_src;
  assign bus.ALUOp     = alu_op;
  assign bus.ImmSrc    = imm_src(bus.op);
  assign bus.Illegal   = illegal_q;
endmodule

// File: tb/tb_multicycle_maindec.sv
// Bench for multicycle_maindec: handshake and fixed-latency instances checked
// against a per-instruction step-list model plus directed corner sequences.
module tb_multicycle_maindec;

  // {MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, A, B, Result, ALUOp}
  typedef struct packed {
    logic       memreq, adrsrc, irwrite, pcwrite, regwrite, memwrite;
    logic [1:0] a, b, res, alu;
  } ctl_t;

  typedef struct {
    ctl_t c;
    bit   acc;
    bit   ill;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         imm, cyc, rw, pw, mw;
  } row_t;

  localparam int LAT = 2;

  localparam ctl_t C_F    = 14'b100000_00_10_10_00;
  localparam ctl_t C_D    = 14'b000000_01_01_00_00;
  localparam ctl_t C_MA   = 14'b000000_10_01_00_00;
  localparam ctl_t C_MR   = 14'b110000_00_00_00_00;
  localparam ctl_t C_MWB  = 14'b000010_00_00_01_00;
  localparam ctl_t C_MW   = 14'b110001_00_00_00_00;
  localparam ctl_t C_EXR  = 14'b000000_10_00_00_10;
  localparam ctl_t C_EXI  = 14'b000000_10_01_00_10;
  localparam ctl_t C_WB   = 14'b000010_00_00_00_00;
  localparam ctl_t C_BR   = 14'b000000_10_00_00_01;
  localparam ctl_t C_JAL  = 14'b000100_01_10_00_00;
  localparam ctl_t C_JALR = 14'b000100_10_01_10_00;
  localparam ctl_t C_LNK  = 14'b000000_01_10_00_00;
  localparam ctl_t C_LUI  = 14'b000000_11_01_00_00;
  localparam ctl_t C_AUI  = 14'b000000_01_01_00_00;
  localparam ctl_t C_TRP  = 14'b000000_00_00_00_00;
  localparam ctl_t C_RST  = 14'b000000_00_10_10_00;

  logic clk = 1'b0;
  logic rst_hs = 1'b0;
  logic rst_lat = 1'b0;
  bit   use_lat = 1'b0;
  int   checks = 0;
  int   fails = 0;
  step_t steps[$];
  row_t  tbl[14];
  logic [6:0] legal_ops[9];

  always #5 clk = ~clk;

  multicycle_maindec_if bus_hs();
  multicycle_maindec_if bus_lat();

  multicycle_maindec #(.MEM_HANDSHAKE(1), .MEM_LATENCY(0), .CNT_W(4)) u_hs (
    .clk(clk), .reset(rst_hs), .bus(bus_hs));
  multicycle_maindec #(.MEM_HANDSHAKE(0), .MEM_LATENCY(LAT), .CNT_W(4)) u_lat (
    .clk(clk), .reset(rst_lat), .bus(bus_lat));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic ctl_t dut_ctl();
    if (use_lat)
      return {bus_lat.MemReq, bus_lat.AdrSrc, bus_lat.IRWrite, bus_lat.PCWrite,
              bus_lat.RegWrite, bus_lat.MemWrite, bus_lat.ALUSrcA, bus_lat.ALUSrcB,
              bus_lat.ResultSrc, bus_lat.ALUOp};
    return {bus_hs.MemReq, bus_hs.AdrSrc, bus_hs.IRWrite, bus_hs.PCWrite,
            bus_hs.RegWrite, bus_hs.MemWrite, bus_hs.ALUSrcA, bus_hs.ALUSrcB,
            bus_hs.ResultSrc, bus_hs.ALUOp};
  endfunction

  function automatic logic [2:0] dut_imm();
    return use_lat ? bus_lat.ImmSrc : bus_hs.ImmSrc;
  endfunction

  function automatic logic dut_ill();
    return use_lat ? bus_lat.Illegal : bus_hs.Illegal;
  endfunction

  function automatic logic [2:0] imm_exp(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic mr);
    bus_hs.op = op;  bus_hs.funct3 = f3;  bus_hs.Zero = z;  bus_hs.MemReady = mr;
    bus_lat.op = op; bus_lat.funct3 = f3; bus_lat.Zero = z; bus_lat.MemReady = mr;
  endtask

  // Expected per-phase behaviour of one instruction, straight from its class.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z);
    ctl_t br;
    steps.delete();
    steps.push_back('{C_F, 1'b1, 1'b0});
    steps.push_back('{C_D, 1'b0, 1'b0});
    case (op)
      7'b0000011: begin
        steps.push_back('{C_MA, 1'b0, 1'b0});
        steps.push_back('{C_MR, 1'b1, 1'b0});
        steps.push_back('{C_MWB, 1'b0, 1'b0});
      end
      7'b0100011: begin
        steps.push_back('{C_MA, 1'b0, 1'b0});
        steps.push_back('{C_MW, 1'b1, 1'b0});
      end
      7'b0110011: begin steps.push_back('{C_EXR, 1'b0, 1'b0}); steps.push_back('{C_WB, 1'b0, 1'b0}); end
      7'b0010011: begin steps.push_back('{C_EXI, 1'b0, 1'b0}); steps.push_back('{C_WB, 1'b0, 1'b0}); end
      7'b1100011: begin
        br = C_BR;
        br.pcwrite = f3[0] ? ~z : z;
        steps.push_back('{br, 1'b0, 1'b0});
      end
      7'b1101111: begin steps.push_back('{C_JAL, 1'b0, 1'b0}); steps.push_back('{C_WB, 1'b0, 1'b0}); end
      7'b1100111: begin
        steps.push_back('{C_JALR, 1'b0, 1'b0});
        steps.push_back('{C_LNK, 1'b0, 1'b0});
        steps.push_back('{C_WB, 1'b0, 1'b0});
      end
      7'b0110111: begin steps.push_back('{C_LUI, 1'b0, 1'b0}); steps.push_back('{C_WB, 1'b0, 1'b0}); end
      7'b0010111: begin steps.push_back('{C_AUI, 1'b0, 1'b0}); steps.push_back('{C_WB, 1'b0, 1'b0}); end
      default: for (int t = 0; t < 20; t++) steps.push_back('{C_TRP, 1'b0, 1'b1});
    endcase
  endtask

  // Starts just after a rising edge with the DUT in FETCH; dly<0 picks a random ready delay.
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic z, input int dly,
                     output int ncyc, output int nrw, output int nmw);
    ctl_t exp, act;
    ncyc = 0; nrw = 0; nmw = 0;
    build(op, f3, z);
    for (int i = 0; i < steps.size(); i++) begin
      int d, k;
      bit done, fin;
      d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
      k = 0; fin = 1'b0;
      while (!fin) begin
        logic mr;
        if (steps[i].acc) begin
          done = use_lat ? (k == LAT) : (k >= d);
          mr   = use_lat ? 1'($urandom_range(0, 1)) : (k >= d);
        end else begin
          done = 1'b1;
          mr   = 1'($urandom_range(0, 1));
        end
        drive(op, f3, z, mr);
        exp = steps[i].c;
        if (steps[i].acc && !exp.adrsrc) begin
          exp.irwrite = done;
          exp.pcwrite = done;
        end
        @(negedge clk);
        act = dut_ctl();
        chk($sformatf("ctl op=%b f3=%b z=%b step=%0d k=%0d", op, f3, z, i, k), 32'(act), 32'(exp));
        chk($sformatf("imm op=%b", op), 32'(dut_imm()), 32'(imm_exp(op)));
        chk($sformatf("illegal op=%b step=%0d", op, i), 32'(dut_ill()), 32'(steps[i].ill));
        ncyc++;
        nrw += int'(act.regwrite);
        nmw += int'(act.memwrite);
        @(posedge clk); #1;
        k++;
        fin = done || (k >= 20);
      end
    end
  endtask

  // Holds the selected instance in reset for one cycle, checks it, releases after an edge.
  task automatic do_reset();
    if (use_lat) rst_lat = 1'b1; else rst_hs = 1'b1;
    @(negedge clk);
    chk("reset ctl", 32'(dut_ctl()), 32'(C_RST));
    chk("reset illegal", 32'(dut_ill()), 32'd0);
    @(posedge clk); #1;
    if (use_lat) rst_lat = 1'b0; else rst_hs = 1'b0;
  endtask

  initial begin
    int nc, nr, nm, cyc, rw, pw, mw;
    bit to;

    tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 0, 5, 1, 1, 0};
    tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 1, 4, 0, 1, 1};
    tbl[2]  = '{7'b0110011, 3'b000, 1'b0, 0, 4, 1, 1, 0};
    tbl[3]  = '{7'b0010011, 3'b000, 1'b1, 0, 4, 1, 1, 0};
    tbl[4]  = '{7'b1100011, 3'b000, 1'b1, 2, 3, 0, 2, 0};
    tbl[5]  = '{7'b1100011, 3'b000, 1'b0, 2, 3, 0, 1, 0};
    tbl[6]  = '{7'b1100011, 3'b001, 1'b0, 2, 3, 0, 2, 0};
    tbl[7]  = '{7'b1100011, 3'b001, 1'b1, 2, 3, 0, 1, 0};
    tbl[8]  = '{7'b1100011, 3'b110, 1'b1, 2, 3, 0, 2, 0};
    tbl[9]  = '{7'b1100011, 3'b111, 1'b1, 2, 3, 0, 1, 0};
    tbl[10] = '{7'b1101111, 3'b000, 1'b0, 3, 4, 1, 2, 0};
    tbl[11] = '{7'b1100111, 3'b000, 1'b0, 0, 5, 1, 2, 0};
    tbl[12] = '{7'b0110111, 3'b000, 1'b0, 4, 4, 1, 1, 0};
    tbl[13] = '{7'b0010111, 3'b000, 1'b0, 4, 4, 1, 1, 0};
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    drive(7'b0110011, 3'b000, 1'b0, 1'b1);
    #1;
    rst_hs = 1'b1; rst_lat = 1'b1;
    use_lat = 1'b0;
    do_reset();

    // Table: MemReady always high, instruction length measured IRWrite to IRWrite.
    @(negedge clk);
    chk("first fetch irwrite", 32'(bus_hs.IRWrite), 32'd1);
    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].op, tbl[r].f3, tbl[r].z, 1'b1);
      #1;
      chk($sformatf("tbl%0d imm", r), 32'(bus_hs.ImmSrc), 32'(tbl[r].imm));
      cyc = 0; rw = 0; pw = 0; mw = 0; to = 1'b1;
      for (int c = 0; c < 20; c++) begin
        rw += int'(bus_hs.RegWrite);
        pw += int'(bus_hs.PCWrite);
        mw += int'(bus_hs.MemWrite);
        cyc++;
        @(negedge clk);
        if (bus_hs.IRWrite) begin to = 1'b0; break; end
      end
      chk($sformatf("tbl%0d timeout", r), 32'(to), 32'd0);
      chk($sformatf("tbl%0d cycles", r), 32'(cyc), 32'(tbl[r].cyc));
      chk($sformatf("tbl%0d regwrites", r), 32'(rw), 32'(tbl[r].rw));
      chk($sformatf("tbl%0d pcwrites", r), 32'(pw), 32'(tbl[r].pw));
      chk($sformatf("tbl%0d memwrites", r), 32'(mw), 32'(tbl[r].mw));
    end
    do_reset();

    // lw with MemReady held off 3 cycles in both FETCH and MEMREAD
    run(7'b0000011, 3'b010, 1'b0, 3, nc, nr, nm);
    chk("lw wait cycles", 32'(nc), 32'd11);
    chk("lw regwrites", 32'(nr), 32'd1);
    run(7'b1100111, 3'b000, 1'b0, 0, nc, nr, nm);
    run(7'b0110111, 3'b000, 1'b0, 0, nc, nr, nm);
    for (int n = 0; n < 40; n++)
      run(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          -1, nc, nr, nm);

    // illegal opcode: absorbing trap, sticky flag until reset
    run(7'b1111111, 3'b000, 1'b0, 0, nc, nr, nm);
    chk("trap cycles", 32'(nc), 32'd22);
    rst_hs = 1'b1;
    #1;
    chk("trap reset illegal", 32'(bus_hs.Illegal), 32'd0);
    chk("trap reset memreq", 32'(bus_hs.MemReq), 32'd0);
    @(posedge clk); #1;
    rst_hs = 1'b0;
    run(7'b0110011, 3'b000, 1'b0, 0, nc, nr, nm);

    // fixed-latency instance
    rst_hs = 1'b1;
    use_lat = 1'b1;
    do_reset();
    run(7'b0100011, 3'b010, 1'b0, 0, nc, nr, nm);
    chk("sw memwrite cycles", 32'(nm), 32'd3);
    chk("sw total cycles", 32'(nc), 32'd8);
    run(7'b0110011, 3'b000, 1'b0, 0, nc, nr, nm);

    // reset during the MEMWRITE wait
    drive(7'b0100011, 3'b010, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("memwrite before reset", 32'(bus_lat.MemWrite), 32'd1);
    #2;
    rst_lat = 1'b1;
    #1;
    chk("memwrite on reset", 32'(bus_lat.MemWrite), 32'd0);
    chk("memreq on reset", 32'(bus_lat.MemReq), 32'd0);
    @(posedge clk); #1;
    rst_lat = 1'b0;
    run(7'b0010011, 3'b000, 1'b0, 0, nc, nr, nm);
    for (int n = 0; n < 40; n++)
      run(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          -1, nc, nr, nm);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
